demux_stream: RTL
=================

Name: demux_stream

Overview:
Parametrised, registered 1-to-N stream demultiplexer. It generalises the 8-bit 2-way combinational demux to WIDTH bits and CHANNELS outputs, with a valid/ready handshake and one output register per channel. It also adds packet locking: the route is chosen on the first beat and held until the last beat. It sits between a single producer (bus/ALU result path) and several consumers (register banks, I/O ports).

Parameters:
WIDTH, 8, data bits per beat
CHANNELS, 4, number of output channels (2..16)
SEL_WIDTH, 2, select width; must satisfy 2^SEL_WIDTH >= CHANNELS
COUNT_WIDTH, 8, width of dropped-beat counter

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in  input  WIDTH  input data beat
in_valid  input  1  producer has a beat
in_ready  output  1  beat accepted this cycle when in_valid && in_ready
in_last  input  1  beat is last of packet
select  input  SEL_WIDTH  destination channel; sampled only on the first beat of a packet
out  output  CHANNELS*WIDTH  channel i data at bits [i*WIDTH +: WIDTH]
out_valid  output  CHANNELS  channel i register holds a beat
out_ready  input  CHANNELS  consumer i takes the beat when out_valid[i] && out_ready[i]
out_last  output  CHANNELS  in_last of the beat held in channel i
drop_count  output  COUNT_WIDTH  saturating count of dropped beats
busy  output  1  FSM in LOCKED

Behaviour:
- Reset (async assert, sync deassert edge irrelevant): out_valid=0, out=0, out_last=0, drop_count=0, FSM=IDLE, busy=0, locked route=0. Asserting reset mid-packet discards all held beats and the lock.
- Route: in IDLE, route=select. In LOCKED, route=locked_sel and select is ignored.
- Invalid route: select >= CHANNELS. The beat is dropped, in_ready=1, drop_count += 1, saturating at all-ones. If the beat is not last, the FSM locks onto the invalid route and the whole packet is dropped.
- Channel register i is free when out_valid[i]=0, or when out_valid[i]=1 && out_ready[i]=1 (same-cycle drain and refill allowed).
- in_ready = free(route) for a valid route. in_ready is combinational from out_ready, select and state. It has no dependency on in_valid.
- Accept on a valid route: next cycle out_valid[route]=1, data=in, out_last[route]=in_last. Latency is 1 cycle. Throughput is 1 beat/cycle per channel when the consumer is always ready.
- Drain without refill: out_valid[i] goes to 0 next cycle.
- Output data lane i is forced to 0 whenever out_valid[i]=0. Unselected and empty channels read 0. out_last[i] is 0 when out_valid[i]=0.
- Holding: while out_valid[i]=1 && out_ready[i]=0, lane i data and last are stable.
- FSM transitions:
  - IDLE -> LOCKED on an accepted (or dropped) beat with in_last=0; locked_sel = select.
  - LOCKED -> IDLE on an accepted (or dropped) beat with in_last=1.
  - A single-beat packet (in_last=1 in IDLE) stays in IDLE.
  - No transition without a handshake.
- busy = (state==LOCKED).
- Channels drain independently. A stalled channel blocks only input beats routed to it.
- If in_valid=0, no state changes except channel drains.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, in=8'hAA -> out=0, out_valid=0, drop_count=0, in_ready has no effect. Release, then send select=2, in=8'h5A, in_last=1 -> next cycle out_valid=4'b0100, lane 2 reads 8'h5A, other lanes read 0.
- Streaming: out_ready=4'hF, 8 beats 8'h01..8'h08 to channel 1, one per cycle -> lane 1 shows 01..08 on consecutive cycles, in_ready stays 1, out_valid[1] stays 1 throughout.
- Back-pressure: channel 3 full with out_ready[3]=0 and select=3 -> in_ready=0 and lane 3 holds its value. Meanwhile select=0 -> beat accepted into channel 0. Raise out_ready[3] -> same-cycle refill, in_ready=1.
- Packet lock: a 3-beat packet starts with select=1, select is toggled to 0/2 on beats 2-3 -> all 3 beats appear on channel 1, busy=1 from beat 1 until beat 3 is accepted, out_last[1]=1 only on beat 3.
- Invalid select with CHANNELS=3, SEL_WIDTH=2: a 4-beat packet with select=3 -> in_ready=1, no out_valid rises, drop_count=4. Preload drop_count to 8'hFE and drop 4 more -> drop_count=8'hFF (saturates).
- Mid-packet reset: assert rst_n=0 after beat 2 of 4 -> busy=0, out_valid=0. The next packet with select=2 routes to channel 2.

Source files
------------

// File: rtl/demux_stream.sv
// Registered 1-to-N stream demultiplexer with valid/ready handshaking.
// The route is taken from select on a packet's first beat and held until its last beat.
module demux_stream #(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 4,
    parameter int SEL_WIDTH   = 2,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          in,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [SEL_WIDTH-1:0]      select,
    output logic [CHANNELS*WIDTH-1:0] out,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CHANNELS-1:0]       out_last,
    output logic [COUNT_WIDTH-1:0]    drop_count,
    output logic                      busy
);

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_t;

    state_t                 r_state;
    logic [SEL_WIDTH-1:0]   r_locked_sel;
    logic [CHANNELS-1:0]    r_valid;
    logic [CHANNELS-1:0]    r_last;
    logic [WIDTH-1:0]       r_data [CHANNELS];
    logic [COUNT_WIDTH-1:0] r_drop;

    logic [SEL_WIDTH-1:0]   w_route;
    logic [CHANNELS-1:0]    w_free;
    logic [CHANNELS-1:0]    w_load;
    logic                   w_hit;
    logic                   w_ready;
    logic                   w_accept;

    assign w_route  = (r_state == S_LOCKED) ? r_locked_sel : select;
    assign w_free   = ~r_valid | out_ready;
    assign w_accept = in_valid && w_ready;

    // An out-of-range route matches no channel, so it is always ready and the beat is dropped.
    always_comb begin
        w_ready = 1'b1;
        w_hit   = 1'b0;
        w_load  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_route == SEL_WIDTH'(i)) begin
                w_ready   = w_free[i];
                w_hit     = 1'b1;
                w_load[i] = in_valid && w_free[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_last  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_load[i]) begin
                    r_valid[i] <= 1'b1;
                    r_data[i]  <= in;
                    r_last[i]  <= in_last;
                end else if (out_ready[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_locked_sel <= '0;
            r_drop       <= '0;
        end else begin
            if (w_accept && !w_hit && (r_drop != '1)) begin
                r_drop <= r_drop + COUNT_WIDTH'(1);
            end
            if (w_accept) begin
                case (r_state)
                    S_IDLE: begin
                        if (!in_last) begin
                            r_state      <= S_LOCKED;
                            r_locked_sel <= select;
                        end
                    end
                    S_LOCKED: begin
                        if (in_last) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Empty lanes read as zero so consumers never see stale data.
    always_comb begin
        out = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            out[i*WIDTH +: WIDTH] = r_valid[i] ? r_data[i] : '0;
        end
    end

    assign in_ready   = w_ready;
    assign out_valid  = r_valid;
    assign out_last   = r_last & r_valid;
    assign drop_count = r_drop;
    assign busy       = (r_state == S_LOCKED);

endmodule
